vit_tb_ctrl: RTL
================

Name: vit_tb_ctrl

Overview:
- Traceback controller and survivor-memory scheduler for the 4-state (K=3) Viterbi decoder.
- Accepts one decision vector per trellis step from the ACS/SMU datapath and stores it in an internal circular survivor memory.
- Sequences windowed traceback over that memory and drains decoded bits in forward order through a valid/ready output.
- Sits between the ACS/SMU stage and the bit sink. Also handles end-of-block flush for zero-tail terminated frames.

Parameters:
- TB_DEPTH, 8: traceback/decode window length in trellis steps.
- MEM_DEPTH, 16: survivor memory depth in steps; power of 2; must be >= 2*TB_DEPTH.
- ADDR_W, 4: log2(MEM_DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  decision vector present.
- in_ready  output  1  controller can accept a step.
- dec_in  input  4  decision bit per state; bit s is the survivor select for state s.
- best_state  input  2  minimum-metric state for this step.
- flush  input  1  end of block; decode all stored steps from state 0.
- out_valid  output  1  decoded bit present.
- out_ready  input  1  sink accepts bit.
- out_bit  output  1  decoded bit.
- out_last  output  1  final bit of a flush drain.
- busy  output  1  high whenever the FSM is not in ACCEPT.

Behaviour:
- State encoding: s = {u(t), u(t-1)}.
  - Predecessor of s = {s[0], dec[t][s]}.
  - Decoded bit of step t = s[1].
- Memory: MEM_DEPTH x 6-bit register array holding {best_state, dec_in}, read combinationally.
  - wr_ptr, tb_ptr are ADDR_W bits and wrap modulo MEM_DEPTH.
  - cnt = number of stored steps, range 0..2*TB_DEPTH.
- Reset (rst=0, async): FSM=ACCEPT, wr_ptr=0, cnt=0, LIFO empty. Outputs during and immediately after reset: in_ready=0 while rst=0, out_valid=0, out_bit=0, out_last=0, busy=0.
- ACCEPT: in_ready=1.
  - Handshake (in_valid&in_ready): write mem[wr_ptr], wr_ptr++, cnt++.
  - If flush=1 and cnt_after>0 → TRACE in flush mode. Start state 0, tb_ptr=wr_ptr_after-1, discard=0, emit=cnt_after.
  - Else if cnt_after==2*TB_DEPTH → TRACE in normal mode. Start state = best_state of newest step, tb_ptr=newest, discard=TB_DEPTH, emit=TB_DEPTH.
  - flush with cnt_after==0 is ignored.
  - Flush has priority over the window-full trigger in the same cycle.
- TRACE: in_ready=0. One step per cycle:
  - d = mem[tb_ptr][tb_state].
  - If the discard count is exhausted, push tb_state[1] onto the output LIFO (depth 2*TB_DEPTH).
  - tb_state <= {tb_state[0], d}, tb_ptr--.
  - Ends after discard+emit cycles → OUTPUT.
  - Latency from the triggering write to first out_valid = discard+emit+1 cycles.
- OUTPUT: out_valid=1, out_bit = LIFO top (oldest step first). Pop on out_valid&out_ready.
  - out_bit must be held stable while out_ready=0.
  - out_last=1 only with the final bit of a flush drain.
  - When the LIFO empties:
    - Normal mode: cnt=TB_DEPTH (oldest window retired), → ACCEPT.
    - Flush mode: wr_ptr=0, cnt=0, → ACCEPT.
- in_valid and flush are ignored outside ACCEPT. The source must hold in_valid until accepted.
- An async reset mid-TRACE or mid-OUTPUT aborts immediately. Partial output is discarded, and no out_last is produced.

Test Plan:
- Reset: assert rst=0 mid-OUTPUT with out_valid=1 → out_valid=0 and busy=0 at once. After release, in_ready=1 and cnt=0. 16 new all-zero steps yield a fresh 8-bit window.
- All-zero stream: 16 steps with dec_in=0000, best_state=0 → in_ready low for 16 TRACE cycles plus drain. Exactly 8 bits are output, all 0, out_last=0. in_ready returns and the second window triggers after 8 further steps.
- Known path u=1,0,1,1,0,1,0,0,1,1,… with dec_in=all bits u(t-2) and best_state={u(t),u(t-1)} → first window outputs 1,0,1,1,0,1,0,0 in order.
- Flush: 5 steps encoding u=1,1,0,0,0, then flush=1 with the 6th step (u=0) → 6 bits 1,1,0,0,0,0. out_last is high only on the 6th bit, then cnt=0.
- Backpressure: out_ready=0 for 3 cycles mid-drain → out_valid stays 1 and out_bit is unchanged. No bits are lost or duplicated, and the total count is still 8.
- Boundaries: flush with cnt=0 → no state change and no output. Flush in the same cycle as the 16th write → flush mode, 16 bits output, out_last on the 16th. wr_ptr wraps 15→0 across windows with correct output.

Source files
------------

// File: rtl/vit_tb_ctrl.sv
// Traceback controller and survivor-memory scheduler for a 4-state (K=3) Viterbi decoder.
// Stores one decision vector per step, runs windowed or flush traceback, drains bits oldest-first.
module vit_tb_ctrl #(
  parameter int TB_DEPTH  = 8,
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] dec_in,
  input  logic [1:0] best_state,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);

  localparam int LIFO_D  = 2 * TB_DEPTH;
  localparam int LIFO_AW = $clog2(LIFO_D);
  localparam int CNT_W   = $clog2(LIFO_D + 1);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_TRACE  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam logic [CNT_W-1:0]  C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0]  C_TB   = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]  C_WIN  = CNT_W'(LIFO_D);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [5:0]        r_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_tb_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_tb_state;
  logic [CNT_W-1:0]  r_step;
  logic [CNT_W-1:0]  r_disc;
  logic [CNT_W-1:0]  r_total;
  logic              r_flush_mode;
  logic [LIFO_D-1:0] r_lifo;
  logic [CNT_W-1:0]  r_lcnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_bit;
  logic              r_out_last;
  logic              r_busy;

  logic              w_acc_en;
  logic              w_hs;
  logic [CNT_W-1:0]  w_cnt_after;
  logic [ADDR_W-1:0] w_wr_after;
  logic              w_start_flush;
  logic              w_start_norm;
  logic [5:0]        w_rd;
  logic [3:0]        w_rd_dec;
  logic [1:0]        w_cur_state;
  logic              w_dec;
  logic              w_trace_last;
  logic              w_push;
  logic              w_pop;
  logic [LIFO_AW-1:0] w_push_idx;
  logic [LIFO_AW-1:0] w_top_idx;
  logic [LIFO_AW-1:0] w_sec_idx;

  assign w_acc_en      = (r_state == ST_ACCEPT) && r_in_ready;
  assign w_hs          = w_acc_en && in_valid;
  assign w_cnt_after   = r_cnt + {{(CNT_W-1){1'b0}}, w_hs};
  assign w_wr_after    = r_wr_ptr + {{(ADDR_W-1){1'b0}}, w_hs};
  // Flush wins over the window-full trigger when both land in the same cycle.
  assign w_start_flush = w_acc_en && flush && (w_cnt_after != C_ZERO);
  assign w_start_norm  = w_hs && !w_start_flush && (w_cnt_after == C_WIN);

  assign w_rd     = r_mem[r_tb_ptr];
  assign w_rd_dec = w_rd[3:0];
  // A normal window starts from the newest step's stored best state.
  assign w_cur_state  = ((r_step == C_ZERO) && !r_flush_mode) ? w_rd[5:4] : r_tb_state;
  assign w_dec        = w_rd_dec[w_cur_state];
  assign w_trace_last = (r_step == r_total);
  assign w_push       = !w_trace_last && (r_step >= r_disc);
  assign w_pop        = (r_state == ST_OUTPUT) && r_out_valid && out_ready;

  assign w_push_idx = LIFO_AW'(r_lcnt);
  assign w_top_idx  = LIFO_AW'(r_lcnt - C_ONE);
  assign w_sec_idx  = LIFO_AW'(r_lcnt - C_TWO);

  // Controller FSM, survivor memory, traceback datapath, output LIFO and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ACCEPT;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 6'd0;
      r_wr_ptr     <= '0;
      r_tb_ptr     <= '0;
      r_cnt        <= C_ZERO;
      r_tb_state   <= 2'b00;
      r_step       <= C_ZERO;
      r_disc       <= C_ZERO;
      r_total      <= C_ZERO;
      r_flush_mode <= 1'b0;
      r_lifo       <= '0;
      r_lcnt       <= C_ZERO;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else begin
            if (w_hs) begin
              r_mem[r_wr_ptr] <= {best_state, dec_in};
              r_wr_ptr        <= w_wr_after;
              r_cnt           <= w_cnt_after;
            end
            if (w_start_flush || w_start_norm) begin
              r_state      <= ST_TRACE;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b1;
              r_tb_ptr     <= w_wr_after - A_ONE;
              r_tb_state   <= 2'b00;
              r_step       <= C_ZERO;
              r_lcnt       <= C_ZERO;
              r_flush_mode <= w_start_flush;
              r_disc       <= w_start_flush ? C_ZERO : C_TB;
              r_total      <= w_start_flush ? w_cnt_after : C_WIN;
            end
          end
        end
        ST_TRACE: begin
          if (w_trace_last) begin
            // Extra cycle loads the output register with the oldest decoded bit.
            r_state     <= ST_OUTPUT;
            r_out_valid <= 1'b1;
            r_out_bit   <= r_lifo[w_top_idx];
            r_out_last  <= r_flush_mode && (r_lcnt == C_ONE);
          end else begin
            if (w_push) begin
              r_lifo[w_push_idx] <= w_cur_state[1];
              r_lcnt             <= r_lcnt + C_ONE;
            end
            r_tb_state <= {w_cur_state[0], w_dec};
            r_tb_ptr   <= r_tb_ptr - A_ONE;
            r_step     <= r_step + C_ONE;
          end
        end
        ST_OUTPUT: begin
          if (w_pop) begin
            if (r_lcnt == C_ONE) begin
              r_state      <= ST_ACCEPT;
              r_lcnt       <= C_ZERO;
              r_out_valid  <= 1'b0;
              r_out_bit    <= 1'b0;
              r_out_last   <= 1'b0;
              r_busy       <= 1'b0;
              r_in_ready   <= 1'b1;
              r_flush_mode <= 1'b0;
              if (r_flush_mode) begin
                r_wr_ptr <= '0;
                r_cnt    <= C_ZERO;
              end else begin
                r_cnt    <= C_TB;
              end
            end else begin
              r_lcnt     <= r_lcnt - C_ONE;
              r_out_bit  <= r_lifo[w_sec_idx];
              r_out_last <= r_flush_mode && (r_lcnt == C_TWO);
            end
          end
        end
        default: begin
          r_state     <= ST_ACCEPT;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule
